crc5_sched: RTL and testbench

Round-robin scheduler that shares one 10-stage pipelined CRC-5 datapath (`CRC_5`: N=11, k=5, x^5+x^2+1) among NUM_REQ requesters.
- Accepts at most one 11-bit message per cycle and zero-pads it to N+k bits.
- Carries a tag/data sideband alongside the datapath's un-flagged pipeline, so each CRC is re-associated with its source.
- Delivers {tag, data, crc} through a credit-protected result FIFO with valid/ready backpressure.
- Sits between packet-framing requesters and the link encoder.

---
 rtl/crc5_pkg.sv | 22 ++
 rtl/crc5_res_fifo.sv | 59 +++++
 rtl/crc5_sched.sv | 128 ++++++++++++
 tb/tb_crc5_sched.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc5_pkg.sv
// Shared constants, FIFO entry layout and tag-width helper for the CRC-5 scheduler.
package crc5_pkg;

    localparam int N   = 11;
    localparam int K   = 5;
    localparam int LAT = 10;
    localparam logic [4:0] CRC_POLY = 5'b00101;

    function automatic int tag_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Sized for the default four requesters; raise together with NUM_REQ.
    localparam int TAG_W = tag_w(4);

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [N-1:0]     data;
        logic [K-1:0]     crc;
    } res_entry_t;

endpackage

// File: rtl/crc5_res_fifo.sv
// Generic show-ahead synchronous FIFO; the head entry is visible on pop_data whenever empty=0.
module crc5_res_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Storage carries no reset; empty masks stale contents.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/crc5_sched.sv
// Round-robin, credit-limited issue into an external 10-stage CRC-5 datapath, with a
// tag/data sideband that re-joins each returning CRC and queues {tag, data, crc}.
module crc5_sched #(
    parameter int NUM_REQ = 4,
    parameter int N       = crc5_pkg::N,
    parameter int K       = crc5_pkg::K,
    parameter int LAT     = crc5_pkg::LAT,
    parameter int DEPTH   = 8,
    localparam int TW     = crc5_pkg::tag_w(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*N-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [N+K-1:0]       crc_m,
    input  logic [K-1:0]         crc_in,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [TW-1:0]        res_tag,
    output logic [N-1:0]         res_data,
    output logic [K-1:0]         res_crc
);

    import crc5_pkg::*;

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]      cnt;
    logic [TW-1:0]      rr;
    logic [NUM_REQ-1:0] grant;
    logic [TW-1:0]      gidx;
    logic [N-1:0]       sel_data;
    logic               accept;
    logic               pop;
    logic               fifo_empty;
    res_entry_t         push_e;
    res_entry_t         head_e;

    logic               sb_v    [0:LAT];
    logic [TW-1:0]      sb_tag  [0:LAT];
    logic [N-1:0]       sb_data [0:LAT];

    // Search starts just after the last winner, so a winner drops to lowest priority.
    always_comb begin
        logic          found;
        logic [TW-1:0] cand;
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        cand  = '0;
        for (int j = 1; j <= NUM_REQ; j++) begin
            cand = TW'((int'(rr) + j) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                grant[cand] = 1'b1;
                gidx        = cand;
                found       = 1'b1;
            end
        end
    end

    assign req_ready = grant & {NUM_REQ{(cnt != '0) && !rst}};
    assign accept    = |req_ready;
    assign pop       = res_valid && res_ready;
    assign sel_data  = req_data[int'(gidx)*N +: N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= CW'(DEPTH);
            rr  <= TW'(NUM_REQ - 1);
        end else begin
            if (accept) rr <= gidx;
            case ({accept, pop})
                2'b10:   cnt <= cnt - CW'(1);
                2'b01:   cnt <= cnt + CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Stage 0 loads in step with crc_m, so stage LAT meets crc_in on the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc_m <= '0;
            for (int s = 0; s <= LAT; s++) begin
                sb_v[s]    <= 1'b0;
                sb_tag[s]  <= '0;
                sb_data[s] <= '0;
            end
        end else begin
            crc_m      <= accept ? {sel_data, {K{1'b0}}} : '0;
            sb_v[0]    <= accept;
            sb_tag[0]  <= accept ? gidx : '0;
            sb_data[0] <= accept ? sel_data : '0;
            for (int s = 1; s <= LAT; s++) begin
                sb_v[s]    <= sb_v[s-1];
                sb_tag[s]  <= sb_tag[s-1];
                sb_data[s] <= sb_data[s-1];
            end
        end
    end

    always_comb begin
        push_e      = '0;
        push_e.tag  = sb_tag[LAT];
        push_e.data = sb_data[LAT];
        push_e.crc  = crc_in;
    end

    crc5_res_fifo #(
        .WIDTH ($bits(res_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (sb_v[LAT]),
        .push_data (push_e),
        .pop       (res_ready),
        .pop_data  (head_e),
        .empty     (fifo_empty)
    );

    assign res_valid = !fifo_empty;
    assign res_tag   = res_valid ? head_e.tag  : '0;
    assign res_data  = res_valid ? head_e.data : '0;
    assign res_crc   = res_valid ? head_e.crc  : '0;

endmodule

// File: tb/tb_crc5_sched.sv
// Directed bench for crc5_sched with a behavioural 10-stage CRC-5 datapath standing in for CRC_5.
module tb_crc5_sched;

    localparam int NR = 4, N = 11, K = 5, LAT = 10, TW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid;
    logic [NR*N-1:0]   req_data;
    logic [NR-1:0]     req_ready;
    logic [N+K-1:0]    crc_m;
    logic [K-1:0]      crc_in;
    logic              res_valid;
    logic              res_ready;
    logic [TW-1:0]     res_tag;
    logic [N-1:0]      res_data;
    logic [K-1:0]      res_crc;

    int checks = 0;
    int errors = 0;
    int n_acc  = 0;
    logic [TW+N+K-1:0] exp_q[$];
    logic [N-1:0]      dat_tab [NR];
    logic [K-1:0]      crc_tab [NR];
    logic [K-1:0]      dp [LAT];

    always #5 clk = ~clk;

    crc5_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .crc_m     (crc_m),
        .crc_in    (crc_in),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_tag   (res_tag),
        .res_data  (res_data),
        .res_crc   (res_crc)
    );

    // Stand-in datapath: remainder of the padded message, delayed through LAT registers.
    function automatic logic [K-1:0] crc5(input logic [N+K-1:0] m);
        logic [K-1:0] r;
        r = '0;
        for (int i = N + K - 1; i >= 0; i--) begin
            logic msb;
            msb = r[K-1];
            r   = {r[K-2:0], m[i]};
            if (msb) r = r ^ 5'b00101;
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) dp[i] <= '0;
        end else begin
            dp[0] <= crc5(crc_m);
            for (int i = 1; i < LAT; i++) dp[i] <= dp[i-1];
        end
    end
    assign crc_in = dp[LAT-1];

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [N-1:0] d, input logic [K-1:0] c);
        dat_tab[i]         = d;
        crc_tab[i]         = c;
        req_data[i*N +: N] = d;
    endtask

    // Observe the settled cycle (scoreboard push on accept, compare on pop), then clock once.
    task automatic tick();
        logic [TW+N+K-1:0] e;
        #1;
        chk("grant_onehot0", $onehot0(req_ready), 1);
        if (res_valid && res_ready) begin
            chk("sb_not_empty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_result", {res_tag, res_data, res_crc}, e);
            end
        end
        for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
                exp_q.push_back({TW'(i), dat_tab[i], crc_tab[i]});
                n_acc++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req_valid = '0;
        res_ready = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        n_acc = 0;
    endtask

    task automatic send_one(input int i, input logic [N-1:0] d, input logic [K-1:0] c);
        int lat;
        set_req(i, d, c);
        req_valid = NR'(1) << i;
        res_ready = 1'b0;
        #1;
        chk("single_ready", req_ready, NR'(1) << i);
        tick();
        req_valid = '0;
        chk("single_crc_m", crc_m, {d, 5'b00000});
        lat = 0;
        while (!res_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("single_latency", lat, 11);
        chk("single_tag", res_tag, i);
        chk("single_data", res_data, d);
        chk("single_crc", res_crc, c);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("single_drained", res_valid, 0);
        chk("single_q", exp_q.size(), 0);
    endtask

    task automatic load_tabs();
        set_req(0, 11'h001, 5'h05);
        set_req(1, 11'h002, 5'h0A);
        set_req(2, 11'h400, 5'h1F);
        set_req(3, 11'h7FF, 5'h0A);
    endtask

    initial begin
        int exp_idx;
        int seen;
        rst       = 1'b1;
        req_valid = '1;
        req_data  = '0;
        res_ready = 1'b0;
        for (int i = 0; i < NR; i++) begin
            dat_tab[i] = '0;
            crc_tab[i] = '0;
        end
        #12;
        chk("rst_ready", req_ready, 0);
        chk("rst_crc_m", crc_m, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_tag", res_tag, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_crc", res_crc, 0);
        chk("rst_cnt", dut.cnt, 8);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;

        repeat (6) begin
            tick();
            chk("idle_crc_m", crc_m, 0);
            chk("idle_res_valid", res_valid, 0);
        end

        send_one(2, 11'h001, 5'h05);
        send_one(2, 11'h002, 5'h0A);
        send_one(2, 11'h000, 5'h00);
        send_one(0, 11'h400, 5'h1F);
        send_one(3, 11'h7FF, 5'h0A);

        // Round-robin with continuous drain
        do_reset();
        load_tabs();
        req_valid = '1;
        res_ready = 1'b1;
        exp_idx   = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (req_ready != '0) begin
                chk("rr_grant", req_ready, NR'(1) << exp_idx);
                exp_idx = (exp_idx + 1) % NR;
            end
            tick();
        end
        chk("rr_accepts", n_acc, 20);
        req_valid = '0;
        repeat (20) tick();
        chk("rr_drain_q", exp_q.size(), 0);
        chk("rr_drain_cnt", dut.cnt, 8);

        // Credit stall with consumer blocked
        do_reset();
        load_tabs();
        req_valid = '1;
        res_ready = 1'b0;
        repeat (20) tick();
        chk("stall_accepts", n_acc, 8);
        #1;
        chk("stall_ready", req_ready, 0);
        chk("stall_cnt", dut.cnt, 0);
        chk("stall_fifo_count", dut.u_fifo.count, 8);
        chk("stall_res_valid", res_valid, 1);
        res_ready = 1'b1;
        n_acc     = 0;
        tick();
        res_ready = 1'b0;
        repeat (5) tick();
        chk("stall_one_more", n_acc, 1);
        repeat (8) tick();
        chk("full_fifo_count", dut.u_fifo.count, 8);
        chk("full_cnt", dut.cnt, 0);
        res_ready = 1'b1;
        tick();
        chk("pop_cnt1", dut.cnt, 1);
        #1;
        chk("pop_cnt1_ready", req_ready != '0, 1);
        tick();
        chk("acc_pop_cnt1", dut.cnt, 1);
        #1;
        chk("acc_pop_next_ready", req_ready != '0, 1);
        req_valid = '0;
        repeat (30) tick();
        chk("stall_drain_q", exp_q.size(), 0);
        chk("stall_drain_cnt", dut.cnt, 8);
        chk("stall_drain_valid", res_valid, 0);

        // Reset with five messages in flight
        do_reset();
        load_tabs();
        req_valid = '1;
        res_ready = 1'b1;
        repeat (5) tick();
        req_valid = '0;
        #3;
        rst = 1'b1;
        #1;
        chk("mid_cnt", dut.cnt, 8);
        chk("mid_crc_m", crc_m, 0);
        chk("mid_res_valid", res_valid, 0);
        chk("mid_ready", req_ready, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        seen = 0;
        repeat (15) begin
            tick();
            if (res_valid) seen++;
        end
        chk("mid_no_result", seen, 0);
        send_one(1, 11'h003, 5'h0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
